// File: rtl/sopc_run_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sopc_run_ctrl_pkg
// Description : Shared encodings for the SoPC run controller: reset level,
//               FSM state codes, run end codes and the cycle-counter
//               saturating increment helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package sopc_run_ctrl_pkg;

    localparam logic c_rst_enable = 1'b1;

    typedef logic [1:0] run_state_t;
    localparam run_state_t c_st_reset = 2'd0;
    localparam run_state_t c_st_run   = 2'd1;
    localparam run_state_t c_st_done  = 2'd2;

    typedef logic [1:0] end_code_t;
    localparam end_code_t c_end_none    = 2'b00;
    localparam end_code_t c_end_halt    = 2'b01;
    localparam end_code_t c_end_stall   = 2'b10;
    localparam end_code_t c_end_timeout = 2'b11;

    localparam logic [31:0] c_cycle_max = 32'hFFFF_FFFF;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == c_cycle_max) ? v : v + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_stall_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : pc_stall_watchdog
// Description : Tracks the core PC and counts consecutive cycles on which it
//               did not change. stall_o flags the cycle on which the count
//               reaches STALL_LIMIT-1 with the PC still equal.
// Ports       : clk, rst (async, active-high)
//               en      - count only while enabled (controller in RUN)
//               clr     - first RUN cycle: load the reference, zero the count
//               pc_i    - observed core PC
//               stall_o - combinational stall-detect for the current cycle
// Revision    : 1.0 - initial release
// ============================================================================
module pc_stall_watchdog
    import sopc_run_ctrl_pkg::*;
#(
    parameter int PC_W        = 32,
    parameter int STALL_LIMIT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            clr,
    input  logic [PC_W-1:0] pc_i,
    output logic            stall_o
);

    localparam int c_cnt_w = $clog2(STALL_LIMIT + 1);

    logic [PC_W-1:0]    r_pc_ref;
    logic [c_cnt_w-1:0] r_stall_cnt;
    logic               w_pc_same;

    assign w_pc_same = (pc_i == r_pc_ref);

    always_ff @(posedge clk or posedge rst) begin
        if (rst == c_rst_enable) begin
            r_pc_ref    <= '0;
            r_stall_cnt <= '0;
        end else if (en) begin
            if (clr || !w_pc_same) begin
                r_pc_ref    <= pc_i;
                r_stall_cnt <= '0;
            end else if (r_stall_cnt != c_cnt_w'(STALL_LIMIT)) begin
                r_stall_cnt <= r_stall_cnt + c_cnt_w'(1);
            end
        end
    end

    // The count is about to step to STALL_LIMIT-1 on this edge.
    assign stall_o = en && !clr && w_pc_same &&
                     (r_stall_cnt == c_cnt_w'(STALL_LIMIT - 2));

endmodule
`default_nettype wire

// File: rtl/sopc_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sopc_run_ctrl
// Description : Run controller for the mips32 SoPC. Releases N_RST sub-domain
//               resets in a staggered sequence, supervises the run and ends it
//               on core halt, PC stall or cycle-budget exhaustion.
// Ports       : clk, rst (async, active-high)
//               start        - restart pulse, honoured only in DONE
//               pc_i, halt_i - core observation, used only in RUN
//               sub_rst_o    - registered per-domain resets (active-high)
//               running_o    - state is RUN
//               done_o       - state is DONE
//               end_code_o   - 00 none, 01 halt, 10 stall, 11 timeout
//               cycle_cnt_o  - cycles spent in RUN, saturating
// Revision    : 1.0 - initial release
// ============================================================================
module sopc_run_ctrl
    import sopc_run_ctrl_pkg::*;
#(
    parameter int N_RST       = 2,
    parameter int RST_HOLD    = 10,
    parameter int RST_STAGGER = 4,
    parameter int RUN_CYCLES  = 50,
    parameter int STALL_LIMIT = 16,
    parameter int PC_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PC_W-1:0]  pc_i,
    input  logic             halt_i,
    output logic [N_RST-1:0] sub_rst_o,
    output logic             running_o,
    output logic             done_o,
    output logic [1:0]       end_code_o,
    output logic [31:0]      cycle_cnt_o
);

    localparam int c_rcnt_w = $clog2(RST_HOLD + (N_RST - 1) * RST_STAGGER + 1);

    if (N_RST < 1 || RST_HOLD < 1 || STALL_LIMIT < 2 || RUN_CYCLES < 1 ||
        RST_STAGGER < 0) begin : g_bad_params
        $error("sopc_run_ctrl: illegal parameter set");
    end

    run_state_t          r_state;
    run_state_t          w_state_next;
    logic [c_rcnt_w-1:0] r_rcnt;
    logic [N_RST-1:0]    r_sub_rst;
    end_code_t           r_end_code;
    logic [31:0]         r_cycle_cnt;
    logic [N_RST-1:0]    w_rel_hit;
    logic                w_in_run;
    logic                w_first_run;
    logic                w_stall;
    logic                w_timeout;
    end_code_t           w_end_code;
    logic                w_run_end;

    // Channel i releases once rcnt reaches its own hold length minus one.
    for (genvar gi = 0; gi < N_RST; gi++) begin : g_rel
        localparam int c_rel = RST_HOLD - 1 + gi * RST_STAGGER;
        assign w_rel_hit[gi] = (r_state == c_st_reset) &&
                               (r_rcnt == c_rcnt_w'(c_rel));
    end

    assign w_in_run    = (r_state == c_st_run);
    assign w_first_run = w_in_run && (r_cycle_cnt == 32'd0);

    pc_stall_watchdog #(
        .PC_W        (PC_W),
        .STALL_LIMIT (STALL_LIMIT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .en      (w_in_run),
        .clr     (w_first_run),
        .pc_i    (pc_i),
        .stall_o (w_stall)
    );

    // End decode: halt beats stall beats timeout when they coincide.
    always_comb begin
        w_timeout  = (r_cycle_cnt == 32'(RUN_CYCLES - 1));
        w_end_code = c_end_none;
        if (halt_i)         w_end_code = c_end_halt;
        else if (w_stall)   w_end_code = c_end_stall;
        else if (w_timeout) w_end_code = c_end_timeout;
        w_run_end  = w_in_run && (w_end_code != c_end_none);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst == c_rst_enable) r_state <= c_st_reset;
        else                     r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_reset: if (w_rel_hit[N_RST-1]) w_state_next = c_st_run;
            c_st_run:   if (w_run_end)          w_state_next = c_st_done;
            c_st_done:  if (start)              w_state_next = c_st_reset;
            default:                            w_state_next = c_st_reset;
        endcase
    end

    // Output logic
    always_comb begin
        running_o   = (r_state == c_st_run);
        done_o      = (r_state == c_st_done);
        sub_rst_o   = r_sub_rst;
        end_code_o  = r_end_code;
        cycle_cnt_o = r_cycle_cnt;
    end

    // Datapath: release counter, sub-domain resets, end code, cycle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == c_rst_enable) begin
            r_rcnt      <= '0;
            r_sub_rst   <= '1;
            r_end_code  <= c_end_none;
            r_cycle_cnt <= '0;
        end else begin
            case (r_state)
                c_st_reset: begin
                    r_rcnt    <= r_rcnt + c_rcnt_w'(1);
                    r_sub_rst <= r_sub_rst & ~w_rel_hit;
                    if (w_rel_hit[N_RST-1]) r_cycle_cnt <= '0;
                end
                c_st_run: begin
                    // The ending cycle is counted too.
                    r_cycle_cnt <= sat_inc32(r_cycle_cnt);
                    if (w_run_end) begin
                        r_end_code <= w_end_code;
                        r_sub_rst  <= '1;
                    end
                end
                c_st_done: begin
                    if (start) begin
                        r_rcnt      <= '0;
                        r_end_code  <= c_end_none;
                        r_cycle_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sopc_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sopc_run_ctrl
// Description : Self-checking bench for sopc_run_ctrl. Instance A uses the
//               default parameters; instance B uses N_RST=4, RST_STAGGER=0,
//               RUN_CYCLES=20. Expected run outcomes are queued when a run
//               is launched and popped when the DUT reaches DONE.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sopc_run_ctrl;

    logic        clk   = 1'b0;
    logic        rst   = 1'b0;
    logic        start = 1'b0;
    logic        halt  = 1'b0;
    logic [31:0] pc    = 32'h0;
    logic        sel   = 1'b0;

    always #5 clk = ~clk;

    logic [1:0]  a_sub_rst;
    logic        a_running, a_done;
    logic [1:0]  a_end;
    logic [31:0] a_cnt;
    logic [3:0]  b_sub_rst;
    logic        b_running, b_done;
    logic [1:0]  b_end;
    logic [31:0] b_cnt;

    sopc_run_ctrl u_dut_a (
        .clk (clk), .rst (rst), .start (start), .pc_i (pc), .halt_i (halt),
        .sub_rst_o (a_sub_rst), .running_o (a_running), .done_o (a_done),
        .end_code_o (a_end), .cycle_cnt_o (a_cnt)
    );

    sopc_run_ctrl #(.N_RST(4), .RST_STAGGER(0), .RUN_CYCLES(20)) u_dut_b (
        .clk (clk), .rst (rst), .start (start), .pc_i (pc), .halt_i (halt),
        .sub_rst_o (b_sub_rst), .running_o (b_running), .done_o (b_done),
        .end_code_o (b_end), .cycle_cnt_o (b_cnt)
    );

    logic        s_running, s_done;
    logic [1:0]  s_end;
    logic [31:0] s_cnt;
    logic [3:0]  s_sub_rst;
    assign s_running = sel ? b_running : a_running;
    assign s_done    = sel ? b_done    : a_done;
    assign s_end     = sel ? b_end     : a_end;
    assign s_cnt     = sel ? b_cnt     : a_cnt;
    assign s_sub_rst = sel ? b_sub_rst : {2'b00, a_sub_rst};

    typedef struct {
        logic [1:0]  code;
        logic [31:0] cnt;
    } exp_t;
    exp_t sbq[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; halt = 1'b0; pc = 32'h0;
        repeat (20) @(negedge clk);
        rst = 1'b0;
    endtask

    // Counts negedges after reset release (or after the start edge) until
    // each channel of A drops and RUN is entered; returns at RUN cycle 0.
    task automatic measure_release_a(input string tag);
        int t0 = -1;
        int t1 = -1;
        int tr = -1;
        for (int n = 1; n <= 40 && tr < 0; n++) begin
            @(negedge clk);
            if (t0 < 0 && a_sub_rst[0] == 1'b0) t0 = n;
            if (t1 < 0 && a_sub_rst[1] == 1'b0) t1 = n;
            if (tr < 0 && a_running === 1'b1)   tr = n;
        end
        n_cmp++;
        if (t0 !== 10) begin n_bad++; $display("FAIL %s ch0_release: got %0d cycles, want 10", tag, t0); end
        n_cmp++;
        if (t1 !== 14) begin n_bad++; $display("FAIL %s ch1_release: got %0d cycles, want 14", tag, t1); end
        n_cmp++;
        if (tr !== 14) begin n_bad++; $display("FAIL %s run_entry: got %0d cycles, want 14", tag, tr); end
    endtask

    // Drives one run from RUN cycle 0 until DONE, then checks the outcome
    // against the scoreboard entry queued by the caller.
    task automatic run_case(input int halt_at, input int freeze_from,
                            input logic [31:0] freeze_pc, input int change_at,
                            input logic [31:0] change_pc, input int start_at,
                            input int budget);
        int   k = 0;
        exp_t e;
        if (s_running !== 1'b1) begin
            n_cmp++; n_bad++;
            $display("FAIL run_start: running=%b, want 1", s_running);
            return;
        end
        while (s_running === 1'b1 && k < budget) begin
            if (k < freeze_from)                     pc = 32'h1000 + 32'(4 * k);
            else if (change_at >= 0 && k >= change_at) pc = change_pc;
            else                                     pc = freeze_pc;
            halt  = (k == halt_at);
            start = (k == start_at);
            @(negedge clk);
            k++;
            if (k == start_at + 1) begin
                n_cmp++;
                if (s_running !== 1'b1 || s_cnt !== 32'(k)) begin
                    n_bad++;
                    $display("FAIL start_in_run: running=%b cnt=%0d, want 1 / %0d", s_running, s_cnt, k);
                end
            end
        end
        halt = 1'b0; start = 1'b0;
        n_cmp++;
        if (s_done !== 1'b1) begin
            n_bad++; $display("FAIL run_end: done=%b after %0d cycles, want 1", s_done, k);
        end
        n_cmp++;
        if (s_sub_rst !== (sel ? 4'hF : 4'h3)) begin
            n_bad++; $display("FAIL done_sub_rst: got %h, want %h", s_sub_rst, sel ? 4'hF : 4'h3);
        end
        if (sbq.size() == 0) begin
            n_cmp++; n_bad++; $display("FAIL scoreboard: queue empty at DONE");
        end else begin
            e = sbq.pop_front();
            n_cmp++;
            if (s_end !== e.code) begin
                n_bad++; $display("FAIL end_code: got %b, want %b", s_end, e.code);
            end
            n_cmp++;
            if (s_cnt !== e.cnt) begin
                n_bad++; $display("FAIL cycle_cnt: got %0d, want %0d", s_cnt, e.cnt);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; halt = 1'b1; pc = 32'h0; start = 1'b0;
        repeat (20) @(negedge clk);
        n_cmp++;
        if ({a_sub_rst, a_running, a_done, a_end} !== 6'b11_0_0_00 || a_cnt !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_state: sub_rst=%b run=%b done=%b end=%b cnt=%0d, want 11 0 0 00 0",
                     a_sub_rst, a_running, a_done, a_end, a_cnt);
        end
        // halt stays high through RESET; it must not matter there.
        rst = 1'b0;
        measure_release_a("reset");
    endtask

    task automatic test_timeout();
        exp_t e;
        e.code = 2'b11; e.cnt = 32'd50;
        sbq.push_back(e);
        run_case(-1, 1000, 32'h0, -1, 32'h0, 20, 100);
    endtask

    task automatic test_restart();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if ({a_running, a_done, a_end} !== 4'b0000 || a_cnt !== 32'd0 || a_sub_rst !== 2'b11) begin
            n_bad++;
            $display("FAIL restart_clear: run=%b done=%b end=%b cnt=%0d sub_rst=%b, want 0 0 00 0 11",
                     a_running, a_done, a_end, a_cnt, a_sub_rst);
        end
        measure_release_a("restart");
    endtask

    task automatic test_halt();
        exp_t e;
        e.code = 2'b01; e.cnt = 32'd8;
        sbq.push_back(e);
        run_case(7, 1000, 32'h0, -1, 32'h0, -5, 100);
    endtask

    task automatic test_stall();
        exp_t e;
        e.code = 2'b10; e.cnt = 32'd21;
        sbq.push_back(e);
        run_case(-1, 5, 32'h0000_0040, -1, 32'h0, -5, 100);
    endtask

    // Freeze at 0x40 from cycle 5, move to 0x44 on cycle 12 and hold:
    // the count restarts at 12 and reaches STALL_LIMIT-1 on cycle 27.
    task automatic test_stall_change();
        exp_t e;
        e.code = 2'b10; e.cnt = 32'd28;
        sbq.push_back(e);
        run_case(-1, 5, 32'h0000_0040, 12, 32'h0000_0044, -5, 100);
    endtask

    task automatic test_rst_mid_run();
        for (int k = 0; k < 5; k++) begin
            pc = 32'h2000 + 32'(4 * k);
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({a_sub_rst, a_running, a_done, a_end} !== 6'b11_0_0_00 || a_cnt !== 32'd0) begin
            n_bad++;
            $display("FAIL async_rst: sub_rst=%b run=%b done=%b end=%b cnt=%0d, want 11 0 0 00 0",
                     a_sub_rst, a_running, a_done, a_end, a_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        measure_release_a("mid_run_rst");
    endtask

    task automatic test_variant();
        int   tn = -1;
        logic [3:0] rel_val = 4'hF;
        exp_t e;
        sel = 1'b1;
        do_reset();
        for (int n = 1; n <= 40 && tn < 0; n++) begin
            @(negedge clk);
            if (b_sub_rst !== 4'hF) begin
                tn = n;
                rel_val = b_sub_rst;
            end
        end
        n_cmp++;
        if (tn !== 10 || rel_val !== 4'h0) begin
            n_bad++;
            $display("FAIL b_release: first change at %0d to %h, want 10 to 0", tn, rel_val);
        end
        n_cmp++;
        if (b_running !== 1'b1) begin
            n_bad++; $display("FAIL b_run_entry: running=%b, want 1", b_running);
        end
        // Halt, stall and timeout all land on cycle 19; halt wins.
        e.code = 2'b01; e.cnt = 32'd20;
        sbq.push_back(e);
        run_case(19, 4, 32'h0000_0040, -1, 32'h0, -5, 40);
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_restart();
        test_halt();
        test_restart();
        test_stall();
        test_restart();
        test_stall_change();
        test_restart();
        test_rst_mid_run();
        test_variant();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
